// File: rtl/fetch.sv
// fetch - instruction fetch stage feeding decode.
//
// Owns the program counter, reads instruction words over a req/ack memory
// port, fetches an extension word when the opcode asks for one, and presents
// one instruction at a time to decode with a valid strobe. PC redirects from
// branch/jump logic take priority over everything but reset.
//
// Ports:
//   cpu_clk      clock, rising edge
//   cpu_rst      asynchronous reset, active low
//   mem_req      memory read request (held until mem_ack)
//   mem_addr     word address, stable while mem_req=1
//   mem_ack      read complete, mem_rdata valid this cycle
//   mem_rdata    read data
//   stall        decode cannot accept this cycle
//   redirect     load new PC (one-cycle pulse)
//   redirect_pc  redirect target
//   ins          instruction word to decode
//   ext          extension word, 0 when the instruction has none
//   ins_en       ins/ext/pc valid
//   pc           address of the instruction on ins
module fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] EXT_MASK  = 16'h8000,
  parameter logic [15:0] EXT_MATCH = 16'h8000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ins,
  output logic [15:0] ext,
  output logic        ins_en,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    START     = 3'd0,
    FETCH_INS = 3'd1,
    FETCH_EXT = 3'd2,
    ISSUE     = 3'd3,
    DRAIN     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [15:0] ins_buf_q, ins_buf_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] ins_q, ins_d;
  logic [15:0] ext_q, ext_d;
  logic [15:0] pc_q, pc_d;
  logic        ins_en_q, ins_en_d;

  // restart: abandon whatever is in flight and begin a fresh fetch at restart_pc
  logic        restart;
  logic [15:0] restart_pc;
  logic        rdata_ext;

  assign rdata_ext = (mem_rdata & EXT_MASK) == EXT_MATCH;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    ins_buf_d  = ins_buf_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ins_d      = ins_q;
    ext_d      = ext_q;
    pc_d       = pc_q;
    ins_en_d   = ins_en_q;
    restart    = 1'b0;
    restart_pc = redirect_pc;

    unique case (state_q)
      START: begin
        if (redirect) begin
          restart = 1'b1;
        end else begin
          state_d    = FETCH_INS;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end

      FETCH_INS: begin
        if (mem_ack) begin
          if (redirect) begin
            restart = 1'b1;
          end else if (rdata_ext) begin
            // keep the request up, just move it to the extension word
            ins_buf_d  = mem_rdata;
            mem_addr_d = fetch_pc_q + 16'd1;
            state_d    = FETCH_EXT;
          end else begin
            state_d    = ISSUE;
            mem_req_d  = 1'b0;
            ins_d      = mem_rdata;
            ext_d      = 16'h0000;
            pc_d       = fetch_pc_q;
            ins_en_d   = 1'b1;
            fetch_pc_d = fetch_pc_q + 16'd1;
          end
        end else if (redirect) begin
          // request can't be withdrawn: park the target until the ack lands
          pend_pc_d = redirect_pc;
          state_d   = DRAIN;
        end
      end

      FETCH_EXT: begin
        if (mem_ack) begin
          if (redirect) begin
            restart = 1'b1;
          end else begin
            state_d    = ISSUE;
            mem_req_d  = 1'b0;
            ins_d      = ins_buf_q;
            ext_d      = mem_rdata;
            pc_d       = fetch_pc_q;
            ins_en_d   = 1'b1;
            fetch_pc_d = fetch_pc_q + 16'd2;
          end
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
          state_d   = DRAIN;
        end
      end

      ISSUE: begin
        if (redirect) begin
          restart = 1'b1;
        end else if (!stall) begin
          ins_en_d   = 1'b0;
          state_d    = FETCH_INS;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end

      DRAIN: begin
        // latest redirect wins, including one arriving with the ack
        if (redirect) pend_pc_d = redirect_pc;
        if (mem_ack) begin
          restart    = 1'b1;
          restart_pc = redirect ? redirect_pc : pend_pc_q;
        end
      end

      default: state_d = START;
    endcase

    if (restart) begin
      fetch_pc_d = restart_pc;
      ins_en_d   = 1'b0;
      state_d    = FETCH_INS;
      mem_req_d  = 1'b1;
      mem_addr_d = restart_pc;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_q    <= START;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      ins_buf_q  <= 16'h0000;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      ins_q      <= 16'h0000;
      ext_q      <= 16'h0000;
      pc_q       <= 16'h0000;
      ins_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      ins_buf_q  <= ins_buf_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ins_q      <= ins_d;
      ext_q      <= ext_d;
      pc_q       <= pc_d;
      ins_en_q   <= ins_en_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ins      = ins_q;
  assign ext      = ext_q;
  assign ins_en   = ins_en_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch - randomized bench for fetch with an instruction-stream reference
// model: the expected program order is walked over a memory image, each
// accepted instruction is compared against it, and redirects re-aim it.
module tb_fetch;
  localparam logic [15:0] RPC    = 16'h0000;
  localparam logic [15:0] EMASK  = 16'h8000;
  localparam logic [15:0] EMATCH = 16'h8000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] ins, ext, pc;
  logic        ins_en;

  always #5 cpu_clk = ~cpu_clk;

  fetch #(.RESET_PC(RPC), .EXT_MASK(EMASK), .EXT_MATCH(EMATCH)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ins(ins), .ext(ext), .ins_en(ins_en), .pc(pc)
  );

  logic [15:0] mem [0:65535];
  int errs = 0, checks = 0;

  // stimulus knobs
  int lat_min = 0, lat_max = 0, stall_pct = 0, redir_pct = 0, spur_pct = 0;
  int f_mode = 0, f_stall = 0;   // f_mode 1: redirect now, 2: at first unacked request cycle
  logic [15:0] f_pc = 16'h0;
  bit zw = 1'b1;

  // reference model state
  logic [15:0] exp_pc = RPC;
  int cnt = 0, last_acc = 0, n_acc = 0, wait_cnt = 0;
  bit have_last = 1'b0, skip_gap = 1'b0;
  logic [15:0] last_acc_pc = 16'h0;

  // previous-cycle observation
  bit p_req = 0, p_ack = 0, p_ins_en = 0, p_stall = 0, p_redir = 0;
  logic [15:0] p_addr, p_ins, p_ext, p_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_ext(input logic [15:0] w);
    return (w & EMASK) == EMATCH;
  endfunction

  function automatic logic [15:0] rnd_tgt();
    if ($urandom_range(1, 0) == 0) return 16'($urandom_range(255, 0));
    return 16'hFF00 | 16'($urandom_range(255, 0));
  endfunction

  // one cycle: observe outputs, drive inputs for the coming edge, step the model
  task automatic cyc();
    bit req_new, e;
    logic [15:0] w, nx;
    @(negedge cpu_clk);
    cnt++;
    if (p_req && !p_ack) begin
      chk("req_hold", mem_req, 1);
      chk("addr_hold", mem_addr, p_addr);
    end
    if (p_ins_en && p_stall && !p_redir) begin
      chk("en_hold", ins_en, 1);
      chk("ins_hold", ins, p_ins);
      chk("ext_hold", ext, p_ext);
      chk("pc_hold", pc, p_pc);
    end
    if (ins_en) chk("en_noreq", mem_req, 0);

    req_new = mem_req && !(p_req && !p_ack);
    if (req_new) wait_cnt = $urandom_range(lat_max, lat_min);
    if (mem_req) begin
      if (wait_cnt == 0) begin
        mem_ack = 1'b1; mem_rdata = mem[mem_addr];
      end else begin
        mem_ack = 1'b0; wait_cnt--; mem_rdata = 16'($urandom);
      end
    end else begin
      mem_ack = ($urandom_range(99, 0) < spur_pct);
      mem_rdata = 16'($urandom);
    end
    if (f_stall > 0) begin stall = 1'b1; f_stall--; end
    else stall = ($urandom_range(99, 0) < stall_pct);
    redirect = 1'b0;
    redirect_pc = 16'($urandom);
    if (f_mode == 1 || (f_mode == 2 && mem_req && !mem_ack)) begin
      redirect = 1'b1; redirect_pc = f_pc; f_mode = 0;
    end else if ($urandom_range(99, 0) < redir_pct) begin
      redirect = 1'b1; redirect_pc = rnd_tgt();
    end

    if (redirect) begin
      exp_pc = redirect_pc;
      skip_gap = 1'b1;
    end else if (ins_en && !stall) begin
      w  = mem[exp_pc];
      e  = is_ext(w);
      nx = exp_pc + 16'd1;
      chk("pc", pc, exp_pc);
      chk("ins", ins, w);
      chk("ext", ext, e ? mem[nx] : 16'h0000);
      if (zw && have_last && !skip_gap) chk("gap", cnt - last_acc, e ? 3 : 2);
      have_last = 1'b1; last_acc = cnt; skip_gap = 1'b0; n_acc++;
      last_acc_pc = pc;
      exp_pc = exp_pc + (e ? 16'd2 : 16'd1);
    end else if (ins_en && stall) begin
      skip_gap = 1'b1;
    end

    p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
    p_ins_en = ins_en; p_stall = stall; p_redir = redirect;
    p_ins = ins; p_ext = ext; p_pc = pc;
  endtask

  task automatic hold_reset();
    cpu_rst = 1'b0;
    mem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; f_mode = 0; f_stall = 0;
    p_req = 0; p_ack = 0; p_ins_en = 0; p_redir = 0;
    have_last = 0; skip_gap = 0; exp_pc = RPC;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b1;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'h0042;
    mem[4] = 16'h8A01; mem[5] = 16'hBEEF;
    mem[16'hFFFF] = 16'h9ABC;

    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, RPC);
    chk("rst_ins", ins, 0);
    chk("rst_ext", ext, 0);
    chk("rst_en", ins_en, 0);
    chk("rst_pc", pc, 0);
    hold_reset();

    // zero-wait startup: 2 cycles per single-word instruction
    cyc(); chk("st_req", mem_req, 1); chk("st_addr", mem_addr, RPC);
    cyc(); chk("i0_en", ins_en, 1); chk("i0_ins", ins, 16'h1234);
    chk("i0_ext", ext, 0); chk("i0_pc", pc, 0);
    cyc(); chk("i0_drop", ins_en, 0); chk("i1_addr", mem_addr, 16'h0001);
    cyc(); chk("i1_ins", ins, 16'h0042); chk("i1_pc", pc, 16'h0001);

    // two-word instruction at 4, stalled 3 cycles in issue
    f_mode = 1; f_pc = 16'h0004;
    cyc();
    cyc(); chk("x_req", mem_req, 1); chk("x_addr", mem_addr, 16'h0004);
    cyc(); chk("x_ext_addr", mem_addr, 16'h0005);
    f_stall = 3;
    cyc(); chk("x_en", ins_en, 1); chk("x_ins", ins, 16'h8A01);
    chk("x_ext", ext, 16'hBEEF); chk("x_pc", pc, 16'h0004);
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("stl_en", ins_en, 1); chk("stl_req", mem_req, 0); chk("stl_pc", pc, 16'h0004);
    end
    cyc(); chk("x_next", mem_addr, 16'h0006); chk("x_next_req", mem_req, 1);

    // extension word wraps from 0xFFFF to 0x0000
    f_mode = 1; f_pc = 16'hFFFF; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc();
      if (mem_req && mem_addr == 16'hFFFF) found = 1;
    end
    chk("wrap_seen", found, 1);
    cyc(); chk("wrap_ext_addr", mem_addr, 16'h0000);
    cyc(); chk("wrap_ins", ins, 16'h9ABC); chk("wrap_ext", ext, 16'h1234); chk("wrap_pc", pc, 16'hFFFF);
    cyc(); chk("wrap_next", mem_addr, 16'h0001);

    // redirect while a request waits 4 cycles for its ack
    zw = 0; lat_min = 4; lat_max = 4;
    f_mode = 2; f_pc = 16'h0100; found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc();
      if (f_mode == 0 && ins_en && !stall && !redirect) found = 1;
    end
    chk("rdw_found", found, 1);
    chk("rdw_pc", last_acc_pc, 16'h0100);

    // async reset in the middle of an extension fetch
    f_mode = 1; f_pc = 16'h0004; found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc();
      if (f_mode == 0 && mem_req && mem_addr == 16'h0005) found = 1;
    end
    chk("mid_ext_seen", found, 1);
    #2 cpu_rst = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_en", ins_en, 0);
    chk("arst_addr", mem_addr, RPC);
    hold_reset();
    cyc(); chk("rs_req", mem_req, 1); chk("rs_addr", mem_addr, RPC); chk("rs_en", ins_en, 0);

    // random traffic with latency, stalls, spurious acks and redirects
    lat_min = 0; lat_max = 3; stall_pct = 25; redir_pct = 4; spur_pct = 20;
    repeat (4000) cyc();
    redir_pct = 15;
    repeat (1500) cyc();
    // zero-wait, no stall: cycle count per instruction
    zw = 1; lat_max = 0; stall_pct = 0; redir_pct = 2; skip_gap = 1;
    repeat (1500) cyc();

    chk("progress", n_acc > 500, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
